// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the MEM stage.
// Build option ARB_ROUND_ROBIN_EN: ties alternate via last_grant instead of fixed MEM-over-IF priority.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [SEL_W-1:0]  mem_sel,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [SEL_W-1:0]  bus_sel,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_req_if,
    output logic              stall_req_mem
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, RESP} state_t;
    typedef enum logic {GRANT_IF = 1'b0, GRANT_MEM = 1'b1} grant_t;

    state_t              state, state_d;
    grant_t              last_grant, last_grant_d;
    logic                bus_req_d, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_d;
    logic [SEL_W-1:0]    bus_sel_d;
    logic [DATA_W-1:0]   if_rdata_d, mem_rdata_d;
    logic                if_done_d, mem_done_d;
    logic                grant_any, grant_mem;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    always_comb begin : arbitrate
        grant_any = if_req | mem_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req && mem_req) begin
            grant_mem = (last_grant == GRANT_IF);
        end else begin
            grant_mem = mem_req;
        end
`else
        grant_mem = mem_req;
`endif
    end

    // Bus handshake: bus_req and the bus_* qualifiers are raised one cycle after the
    // grant, stay frozen until bus_ack is sampled high, and bus_ack is ignored otherwise.
    always_comb begin : next_state
        state_d      = state;
        last_grant_d = last_grant;
        bus_req_d    = bus_req;
        bus_we_d     = bus_we;
        bus_addr_d   = bus_addr;
        bus_wdata_d  = bus_wdata;
        bus_sel_d    = bus_sel;
        if_rdata_d   = if_rdata;
        mem_rdata_d  = mem_rdata;
        if_done_d    = 1'b0;
        mem_done_d   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    bus_req_d = 1'b1;
                    if (grant_mem) begin
                        state_d      = MEM_BUSY;
                        last_grant_d = GRANT_MEM;
                        bus_we_d     = mem_we;
                        bus_addr_d   = word_align(mem_addr);
                        bus_wdata_d  = mem_wdata;
                        bus_sel_d    = mem_sel;
                    end else begin
                        state_d      = IF_BUSY;
                        last_grant_d = GRANT_IF;
                        bus_we_d     = 1'b0;
                        bus_addr_d   = word_align(if_addr);
                        bus_wdata_d  = '0;
                        bus_sel_d    = '1;
                    end
                end
            end
            IF_BUSY: begin
                if (bus_ack) begin
                    if_rdata_d = bus_rdata;
                    if_done_d  = 1'b1;
                    bus_req_d  = 1'b0;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = '0;
                    state_d    = RESP;
                end
            end
            MEM_BUSY: begin
                if (bus_ack) begin
                    if (!bus_we) begin
                        mem_rdata_d = bus_rdata;
                    end
                    mem_done_d = 1'b1;
                    bus_req_d  = 1'b0;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = '0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                // Turnaround cycle: the finished requester drops or renews here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_IF;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_sel    <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            bus_req    <= bus_req_d;
            bus_we     <= bus_we_d;
            bus_addr   <= bus_addr_d;
            bus_wdata  <= bus_wdata_d;
            bus_sel    <= bus_sel_d;
            if_rdata   <= if_rdata_d;
            mem_rdata  <= mem_rdata_d;
            if_done    <= if_done_d;
            mem_done   <= mem_done_d;
        end
    end

    // Built from the registered done pulses, so ctrl never sees a combinational loop.
    assign stall_req_if  = if_req & ~if_done;
    assign stall_req_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grant order and returned data.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int TR_LEN = 64;
    localparam int TXN_W  = 1 + ADDR_W + DATA_W + SEL_W;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } mem_op_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [SEL_W-1:0]  mem_sel;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [SEL_W-1:0]  bus_sel;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              stall_req_if;
    logic              stall_req_mem;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = -1;

    logic [TR_LEN-1:0] tr_bus_req, tr_bus_we, tr_if_done, tr_mem_done, tr_stall_if, tr_stall_mem;
    logic [ADDR_W-1:0] tr_bus_addr [TR_LEN];
    logic [SEL_W-1:0]  tr_bus_sel  [TR_LEN];

    bit                slave_hold, slave_rand, spurious_ack, rdata_fixed_en, in_txn;
    int                slave_waits, cur_waits, wait_cnt;
    logic [DATA_W-1:0] rdata_fixed;

    logic [ADDR_W-1:0] if_ops [$];
    mem_op_t           mem_ops[$];
    logic [TXN_W-1:0]  obs_q  [$];
    logic [TXN_W-1:0]  exp_q  [$];
    logic [DATA_W-1:0] obs_if_q [$];
    logic [DATA_W-1:0] obs_mem_q[$];
    logic [DATA_W-1:0] exp_if_q [$];
    logic [DATA_W-1:0] exp_mem_q[$];

    // Slave read data as a function of the word address.
    function automatic logic [DATA_W-1:0] rd_func(input logic [ADDR_W-1:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    // ---------------- monitor / slave / requester follow-up (negedge) ----------------
    initial begin : monitor
        mem_op_t op;
        forever begin
            @(negedge clk);
            if (cyc >= 0 && cyc < TR_LEN) begin
                tr_bus_req[cyc]   = bus_req;
                tr_bus_we[cyc]    = bus_we;
                tr_if_done[cyc]   = if_done;
                tr_mem_done[cyc]  = mem_done;
                tr_stall_if[cyc]  = stall_req_if;
                tr_stall_mem[cyc] = stall_req_mem;
                tr_bus_addr[cyc]  = bus_addr;
                tr_bus_sel[cyc]   = bus_sel;
            end
            if (cyc >= 0) cyc++;
            if (if_done) begin
                obs_if_q.push_back(if_rdata);
                if (if_ops.size() > 0) if_addr = if_ops.pop_front();
                else if_req = 1'b0;
            end
            if (mem_done) begin
                obs_mem_q.push_back(mem_rdata);
                if (mem_ops.size() > 0) begin
                    op = mem_ops.pop_front();
                    mem_we = op.we; mem_addr = op.addr; mem_wdata = op.wdata; mem_sel = op.sel;
                end else begin
                    mem_req = 1'b0;
                end
            end
            bus_ack   = spurious_ack;
            bus_rdata = $urandom();
            if (bus_req) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    wait_cnt  = 0;
                    cur_waits = slave_rand ? int'($urandom_range(0, 3)) : slave_waits;
                end
                if (!slave_hold && wait_cnt == cur_waits) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata_fixed_en ? rdata_fixed : rd_func(bus_addr);
                    obs_q.push_back({bus_we, bus_addr, (bus_we ? bus_wdata : 32'h0), bus_sel});
                end
                wait_cnt++;
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_trace();
        tr_bus_req = '0; tr_bus_we = '0; tr_if_done = '0; tr_mem_done = '0;
        tr_stall_if = '0; tr_stall_mem = '0;
        for (int i = 0; i < TR_LEN; i++) begin
            tr_bus_addr[i] = '0;
            tr_bus_sel[i]  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        spurious_ack = 1'b0; slave_hold = 1'b0; slave_rand = 1'b0; slave_waits = 0;
        rdata_fixed_en = 1'b0;
        if_ops.delete(); mem_ops.delete(); obs_q.delete(); exp_q.delete();
        obs_if_q.delete(); obs_mem_q.delete(); exp_if_q.delete(); exp_mem_q.delete();
        cyc = -1;
        clear_trace();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_cycle0();
        @(posedge clk);
        #1 cyc = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'hFFFF_FFFF;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'hFFFF_FFFF; mem_sel = 4'hF;
        spurious_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_cnt++;
        if ({bus_req, bus_we, if_done, mem_done} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b, expected 0000", {bus_req, bus_we, if_done, mem_done});
        else pass_cnt++;
        chk_cnt++;
        if ({bus_addr, bus_wdata, bus_sel} !== '0)
            $display("FAIL reset_bus: got addr %h wdata %h sel %h, expected zeros", bus_addr, bus_wdata, bus_sel);
        else pass_cnt++;
        chk_cnt++;
        if ({if_rdata, mem_rdata} !== '0)
            $display("FAIL reset_rdata: got %h %h, expected zeros", if_rdata, mem_rdata);
        else pass_cnt++;
        chk_cnt++;
        if ({stall_req_if, stall_req_mem} !== 2'b11)
            $display("FAIL reset_stall: got %b, expected 11", {stall_req_if, stall_req_mem});
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_fetch_zero_wait();
        do_reset();
        rdata_fixed_en = 1'b1; rdata_fixed = 32'h2401_0005;
        start_cycle0();
        if_addr = 32'h0000_0004; if_req = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk_cnt++;
        if (tr_bus_req[5:0] !== 6'b000010) $display("FAIL fetch_bus_req: got %b, expected 000010", tr_bus_req[5:0]);
        else pass_cnt++;
        chk_cnt++;
        if (tr_bus_addr[1] !== 32'h4) $display("FAIL fetch_bus_addr: got %h, expected 00000004", tr_bus_addr[1]);
        else pass_cnt++;
        chk_cnt++;
        if ({tr_bus_sel[1], tr_bus_we[1], tr_bus_sel[2]} !== {4'hF, 1'b0, 4'h0})
            $display("FAIL fetch_sel_we: got sel %h we %b sel_after %h, expected F 0 0", tr_bus_sel[1], tr_bus_we[1], tr_bus_sel[2]);
        else pass_cnt++;
        chk_cnt++;
        if (tr_if_done[5:0] !== 6'b000100) $display("FAIL fetch_done: got %b, expected 000100", tr_if_done[5:0]);
        else pass_cnt++;
        chk_cnt++;
        if (if_rdata !== 32'h2401_0005) $display("FAIL fetch_rdata: got %h, expected 24010005", if_rdata);
        else pass_cnt++;
    endtask

    task automatic test_store_wait3();
        logic [DATA_W-1:0] pre;
        do_reset();
        start_cycle0();
        mem_we = 1'b0; mem_addr = 32'h0000_2008; mem_sel = 4'hF; mem_req = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        pre = rd_func(32'h0000_2008);
        chk_cnt++;
        if (mem_rdata !== pre) $display("FAIL load_rdata: got %h, expected %h", mem_rdata, pre);
        else pass_cnt++;
        clear_trace();
        slave_waits = 3;
        start_cycle0();
        mem_we = 1'b1; mem_addr = 32'h0000_1003; mem_sel = 4'b0011; mem_wdata = 32'hDEAD_BEEF; mem_req = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk_cnt++;
        if ({tr_bus_addr[1], tr_bus_we[1], tr_bus_sel[1]} !== {32'h0000_1000, 1'b1, 4'b0011})
            $display("FAIL store_bus: got addr %h we %b sel %b, expected 00001000 1 0011", tr_bus_addr[1], tr_bus_we[1], tr_bus_sel[1]);
        else pass_cnt++;
        chk_cnt++;
        if (bus_wdata !== 32'hDEAD_BEEF) $display("FAIL store_wdata: got %h, expected deadbeef", bus_wdata);
        else pass_cnt++;
        chk_cnt++;
        if (tr_bus_req[7:0] !== 8'b0001_1110) $display("FAIL store_bus_req: got %b, expected 00011110", tr_bus_req[7:0]);
        else pass_cnt++;
        chk_cnt++;
        if (tr_mem_done[7:0] !== 8'b0010_0000) $display("FAIL store_done: got %b, expected 00100000", tr_mem_done[7:0]);
        else pass_cnt++;
        chk_cnt++;
        if (mem_rdata !== pre) $display("FAIL store_rdata_kept: got %h, expected %h", mem_rdata, pre);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        do_reset();
        spurious_ack = 1'b1;
        start_cycle0();
        if_addr = 32'h0000_0102; if_req = 1'b1;
        mem_we = 1'b0; mem_addr = 32'h0000_0207; mem_sel = 4'b1100; mem_req = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk_cnt++;
        if (tr_mem_done[7:0] !== 8'b0000_0100) $display("FAIL tie_mem_done: got %b, expected 00000100", tr_mem_done[7:0]);
        else pass_cnt++;
        chk_cnt++;
        if (tr_if_done[7:0] !== 8'b0010_0000) $display("FAIL tie_if_done: got %b, expected 00100000", tr_if_done[7:0]);
        else pass_cnt++;
        chk_cnt++;
        if (tr_stall_if[5:0] !== 6'b011111) $display("FAIL tie_stall_if: got %b, expected 011111", tr_stall_if[5:0]);
        else pass_cnt++;
        chk_cnt++;
        if (tr_stall_mem[2:0] !== 3'b011) $display("FAIL tie_stall_mem: got %b, expected 011", tr_stall_mem[2:0]);
        else pass_cnt++;
        chk_cnt++;
        if ({tr_bus_addr[1], tr_bus_sel[1], tr_bus_addr[4], tr_bus_sel[4]} !== {32'h0000_0204, 4'b1100, 32'h0000_0100, 4'hF})
            $display("FAIL tie_bus: got %h/%h then %h/%h, expected 00000204/c then 00000100/f",
                     tr_bus_addr[1], tr_bus_sel[1], tr_bus_addr[4], tr_bus_sel[4]);
        else pass_cnt++;
        chk_cnt++;
        if ({if_rdata, mem_rdata} !== {rd_func(32'h0000_0100), rd_func(32'h0000_0204)})
            $display("FAIL tie_rdata: got %h %h, expected %h %h", if_rdata, mem_rdata, rd_func(32'h100), rd_func(32'h204));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        slave_hold = 1'b1;
        start_cycle0();
        mem_we = 1'b0; mem_addr = 32'h0000_3000; mem_sel = 4'hF; mem_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_cnt++;
        if (bus_req !== 1'b1) $display("FAIL midrst_busy: got %b, expected 1", bus_req);
        else pass_cnt++;
        rst_n = 1'b0; mem_req = 1'b0;
        #1;
        chk_cnt++;
        if (bus_req !== 1'b0) $display("FAIL midrst_drop: got %b, expected 0", bus_req);
        else pass_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b1; slave_hold = 1'b0;
        clear_trace();
        cyc = 0;
        spurious_ack = 1'b1;
        @(negedge clk);
        #1 spurious_ack = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk_cnt++;
        if ({tr_mem_done[4:0], tr_bus_req[4:0], mem_rdata} !== '0)
            $display("FAIL midrst_late_ack: got done %b req %b rdata %h, expected zeros", tr_mem_done[4:0], tr_bus_req[4:0], mem_rdata);
        else pass_cnt++;
        clear_trace();
        start_cycle0();
        if_addr = 32'h0000_0040; if_req = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk_cnt++;
        if ({tr_bus_req[3:0], tr_if_done[3:0]} !== {4'b0010, 4'b0100})
            $display("FAIL midrst_idle: got req %b done %b, expected 0010 0100", tr_bus_req[3:0], tr_if_done[3:0]);
        else pass_cnt++;
    endtask

    task automatic test_addr_change_busy();
        int bad;
        do_reset();
        slave_waits = 3;
        start_cycle0();
        mem_we = 1'b0; mem_addr = 32'h0000_5554; mem_sel = 4'hF; mem_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_addr = 32'h0000_9998; mem_we = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        bad = 0;
        for (int i = 1; i <= 4; i++) if (tr_bus_addr[i] !== 32'h0000_5554 || tr_bus_we[i] !== 1'b0) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL busy_hold: got %0d cycles with changed addr/we, expected 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (tr_mem_done[7:0] !== 8'b0010_0000) $display("FAIL busy_done: got %b, expected 00100000", tr_mem_done[7:0]);
        else pass_cnt++;
        chk_cnt++;
        if (mem_rdata !== rd_func(32'h0000_5554)) $display("FAIL busy_rdata: got %h, expected %h", mem_rdata, rd_func(32'h5554));
        else pass_cnt++;
    endtask

    task automatic test_late_request();
        do_reset();
        slave_waits = 2;
        start_cycle0();
        mem_we = 1'b0; mem_addr = 32'h0000_0600; mem_sel = 4'hF; mem_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 if_addr = 32'h0000_0700; if_req = 1'b1;
        repeat (9) @(negedge clk);
        #1;
        chk_cnt++;
        if (tr_bus_req[10:0] !== 11'h1CE) $display("FAIL late_bus_req: got %h, expected 1ce", tr_bus_req[10:0]);
        else pass_cnt++;
        chk_cnt++;
        if ({tr_mem_done[10:0], tr_if_done[10:0]} !== {11'h010, 11'h200})
            $display("FAIL late_done: got mem %h if %h, expected 010 200", tr_mem_done[10:0], tr_if_done[10:0]);
        else pass_cnt++;
    endtask

    // Randomized traffic: both requesters always renew, so the grant order follows
    // directly from the arbitration rule applied to the remaining operation counts.
    task automatic test_random(input int round);
        int n_if, n_mem, ni, nm, budget, bad;
        bit pick_mem, last_mem;
        logic [ADDR_W-1:0] ia [$];
        mem_op_t ma [$];
        mem_op_t op;
        logic [DATA_W-1:0] last_rd;
        do_reset();
        slave_rand = 1'b1;
        n_if  = $urandom_range(2, 6);
        n_mem = $urandom_range(2, 6);
        for (int i = 0; i < n_if; i++) ia.push_back($urandom());
        for (int i = 0; i < n_mem; i++) begin
            op.we = 1'($urandom_range(0, 1)); op.addr = $urandom(); op.wdata = $urandom();
            op.sel = 4'($urandom_range(1, 15));
            ma.push_back(op);
        end
        ni = 0; nm = 0; last_mem = 1'b0; last_rd = '0;
        while (ni < n_if || nm < n_mem) begin
            if (ni < n_if && nm < n_mem) begin
`ifdef ARB_ROUND_ROBIN_EN
                pick_mem = !last_mem;
`else
                pick_mem = 1'b1;
`endif
            end else begin
                pick_mem = (nm < n_mem);
            end
            last_mem = pick_mem;
            if (pick_mem) begin
                op = ma[nm]; nm++;
                exp_q.push_back({op.we, op.addr & ~32'h3, (op.we ? op.wdata : 32'h0), op.sel});
                if (!op.we) last_rd = rd_func(op.addr & ~32'h3);
                exp_mem_q.push_back(last_rd);
            end else begin
                exp_q.push_back({1'b0, ia[ni] & ~32'h3, 32'h0, 4'hF});
                exp_if_q.push_back(rd_func(ia[ni] & ~32'h3));
                ni++;
            end
        end
        for (int i = 1; i < n_if; i++) if_ops.push_back(ia[i]);
        for (int i = 1; i < n_mem; i++) mem_ops.push_back(ma[i]);
        start_cycle0();
        if_addr = ia[0]; if_req = 1'b1;
        mem_we = ma[0].we; mem_addr = ma[0].addr; mem_wdata = ma[0].wdata; mem_sel = ma[0].sel; mem_req = 1'b1;
        budget = 400;
        while ((obs_if_q.size() < n_if || obs_mem_q.size() < n_mem) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (4) @(negedge clk);
        #1;
        chk_cnt++;
        if (budget == 0) $display("FAIL rand%0d_timeout: got %0d/%0d if, %0d/%0d mem completions",
                                  round, obs_if_q.size(), n_if, obs_mem_q.size(), n_mem);
        else pass_cnt++;
        chk_cnt++;
        if (obs_q.size() != exp_q.size() || obs_if_q.size() != n_if || obs_mem_q.size() != n_mem)
            $display("FAIL rand%0d_counts: got bus %0d if %0d mem %0d, expected %0d %0d %0d",
                     round, obs_q.size(), obs_if_q.size(), obs_mem_q.size(), exp_q.size(), n_if, n_mem);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i]) begin
                $display("FAIL rand%0d_bus[%0d]: got %h, expected %h", round, i, obs_q[i], exp_q[i]);
                bad++;
            end else pass_cnt++;
        end
        for (int i = 0; i < n_if && i < obs_if_q.size(); i++) begin
            chk_cnt++;
            if (obs_if_q[i] !== exp_if_q[i]) $display("FAIL rand%0d_if_rdata[%0d]: got %h, expected %h", round, i, obs_if_q[i], exp_if_q[i]);
            else pass_cnt++;
        end
        for (int i = 0; i < n_mem && i < obs_mem_q.size(); i++) begin
            chk_cnt++;
            if (obs_mem_q[i] !== exp_mem_q[i]) $display("FAIL rand%0d_mem_rdata[%0d]: got %h, expected %h", round, i, obs_mem_q[i], exp_mem_q[i]);
            else pass_cnt++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_sel = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        slave_hold = 1'b0; slave_rand = 1'b0; spurious_ack = 1'b0; rdata_fixed_en = 1'b0;
        slave_waits = 0; cur_waits = 0; wait_cnt = 0; in_txn = 1'b0; rdata_fixed = '0;
        clear_trace();
        test_reset();
        test_fetch_zero_wait();
        test_store_wait3();
        test_contention();
        test_reset_mid_access();
        test_addr_change_busy();
        test_late_request();
        for (int r = 0; r < 3; r++) test_random(r);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
